// File: rtl/i2c_slave_responder_if.sv
// Bus bundle between the I2C responder and its environment: pad-side SCL/SDA
// plus the register-bank strobe interface.
interface i2c_slave_responder_if;
  logic       i2c_sclk;
  logic       i2c_sdat_in;
  logic       i2c_sdat_oe;
  logic [7:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic [7:0] reg_rd_data;
  logic       reg_rd_en;
  logic       busy;

  modport slave (
    input  i2c_sclk, i2c_sdat_in, reg_rd_data,
    output i2c_sdat_oe, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy
  );

  modport master (
    output i2c_sclk, i2c_sdat_in, reg_rd_data,
    input  i2c_sdat_oe, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy
  );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C/SCCB target: oversampled SCL/SDA, 7-bit address match, register pointer,
// auto-incrementing burst writes and reads over a strobe register bus.
module i2c_slave_responder #(
  parameter logic [6:0] DEVICE_ADDR = 7'h21,
  parameter int         FILTER_LEN  = 4
) (
  input logic clk,
  input logic rst,
  i2c_slave_responder_if.slave bus
);

  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ACK_ADDR, REG_PTR, ACK_WR, WR_DATA,
    RD_LOAD, RD_DATA, RD_ACK, RD_WAIT
  } state_e;

  // index 0 = SCL, index 1 = SDA
  logic [1:0]      raw, s1_q, s2_q, filt_q, prev_q;
  logic [1:0][3:0] fcnt_q;

  assign raw = {bus.i2c_sdat_in, bus.i2c_sclk};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 2'b11;
      s2_q   <= 2'b11;
      filt_q <= 2'b11;
      prev_q <= 2'b11;
      fcnt_q <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= 4'd0;
        end else if (fcnt_q[i] == CNT_MAX) begin
          filt_q[i] <= s2_q[i];
          fcnt_q[i] <= 4'd0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 4'd1;
        end
      end
    end
  end

  logic scl_rise, scl_fall, sda_bit, start_c, stop_c;
  assign scl_rise = filt_q[0] & ~prev_q[0];
  assign scl_fall = ~filt_q[0] & prev_q[0];
  assign sda_bit  = filt_q[1];
  assign start_c  = ~filt_q[1] & prev_q[1] & filt_q[0];
  assign stop_c   = filt_q[1] & ~prev_q[1] & filt_q[0];

  state_e     state_q;
  logic [3:0] bcnt_q;
  logic [7:0] shift_q, addr_q, wr_data_q;
  logic       rw_q, oe_q, wr_en_q, rd_en_q, busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bcnt_q    <= 4'd0;
      shift_q   <= 8'h00;
      addr_q    <= 8'h00;
      wr_data_q <= 8'h00;
      rw_q      <= 1'b0;
      oe_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      if (start_c) begin
        state_q <= DEV_ADDR;
        bcnt_q  <= 4'd0;
        oe_q    <= 1'b0;
      end else if (stop_c) begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          DEV_ADDR: begin
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], sda_bit};
              bcnt_q  <= bcnt_q + 4'd1;
            end else if (scl_fall && bcnt_q == 4'd8) begin
              if (shift_q[7:1] == DEVICE_ADDR) begin
                oe_q    <= 1'b1;
                busy_q  <= 1'b1;
                rw_q    <= shift_q[0];
                state_q <= ACK_ADDR;
              end else begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end
          end
          ACK_ADDR: begin
            if (scl_fall) begin
              bcnt_q <= 4'd0;
              if (rw_q) begin
                state_q <= RD_LOAD;
              end else begin
                oe_q    <= 1'b0;
                state_q <= REG_PTR;
              end
            end
          end
          REG_PTR: begin
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], sda_bit};
              bcnt_q  <= bcnt_q + 4'd1;
            end else if (scl_fall && bcnt_q == 4'd8) begin
              addr_q  <= shift_q;
              oe_q    <= 1'b1;
              state_q <= ACK_WR;
            end
          end
          ACK_WR: begin
            if (scl_fall) begin
              oe_q    <= 1'b0;
              bcnt_q  <= 4'd0;
              state_q <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], sda_bit};
              bcnt_q  <= bcnt_q + 4'd1;
              if (bcnt_q == 4'd7) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= {shift_q[6:0], sda_bit};
              end
            end else if (scl_fall && bcnt_q == 4'd8) begin
              oe_q    <= 1'b1;
              addr_q  <= addr_q + 8'd1;
              state_q <= ACK_WR;
            end
          end
          RD_LOAD: begin
            // bit 7 goes out now; the shifter keeps bits 6..0 for later falls
            shift_q <= {bus.reg_rd_data[6:0], 1'b1};
            oe_q    <= ~bus.reg_rd_data[7];
            rd_en_q <= 1'b1;
            addr_q  <= addr_q + 8'd1;
            bcnt_q  <= 4'd1;
            state_q <= RD_DATA;
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bcnt_q == 4'd8) begin
                oe_q    <= 1'b0;
                bcnt_q  <= 4'd0;
                state_q <= RD_ACK;
              end else begin
                oe_q    <= ~shift_q[7];
                shift_q <= {shift_q[6:0], 1'b1};
                bcnt_q  <= bcnt_q + 4'd1;
              end
            end
          end
          RD_ACK: begin
            // bcnt_q = 1 marks an ACK seen; the next falling edge fetches a byte
            if (scl_rise) begin
              if (sda_bit) state_q <= RD_WAIT;
              else         bcnt_q  <= 4'd1;
            end else if (scl_fall && bcnt_q == 4'd1) begin
              state_q <= RD_LOAD;
            end
          end
          IDLE, RD_WAIT: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.i2c_sdat_oe = oe_q;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wr_en   = wr_en_q;
  assign bus.reg_wr_data = wr_data_q;
  assign bus.reg_rd_en   = rd_en_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- I2C/SCCB target (responder) that decodes a 7-bit device address, an 8-bit register pointer and data bytes from an external I2C initiator.
- Exposes a simple register-bus strobe interface, so an on-chip register bank or a behavioural sensor model can be driven from the I2C side.
- Serves the camera-configuration path: it can stand in as the sensor end on the bench, or act as a board-level configuration port.
- Samples SCL/SDA as ordinary inputs, oversampled in the `clk` domain; SDA is driven open-drain.

Parameters:
- DEVICE_ADDR, 7'h21, 7-bit target address (SCCB write byte 0x42 / read byte 0x43).
- FILTER_LEN, 4, consecutive equal samples required before a filtered SCL/SDA level changes (1..15).

Ports:
- clk  input  1  system clock; must be ≥ 20× the SCL frequency.
- rst  input  1  synchronous, active-high reset.
- i2c_sclk  input  1  bus SCL (raw, asynchronous).
- i2c_sdat_in  input  1  bus SDA as seen at the pad (raw, asynchronous).
- i2c_sdat_oe  output  1  1 = pull SDA low. The pad drives 0 when this is 1, otherwise Z.
- reg_addr  output  8  current register pointer.
- reg_wr_en  output  1  one-cycle write strobe.
- reg_wr_data  output  8  write data, valid while reg_wr_en is high.
- reg_rd_data  input  8  read data for reg_addr; combinational or stable ≥ 1 cycle after reg_addr changes.
- reg_rd_en  output  1  one-cycle strobe when a read byte is loaded; the pointer advances afterwards.
- busy  output  1  high from an address-matched START until STOP.

Behaviour:
- **Input conditioning:** 2-flop synchronizer per line, then a glitch filter. The filtered level updates only after FILTER_LEN equal samples. Edge pulses scl_rise and scl_fall, plus sda_fall/sda_rise, are taken from the filtered levels.
- **START** = sda_fall while SCL is high. **STOP** = sda_rise while SCL is high. Both are valid in any state.
- START (including a repeated START) → state DEV_ADDR, bit count 0, i2c_sdat_oe = 0.
- STOP → IDLE, i2c_sdat_oe = 0, busy = 0. reg_addr is retained across STOP.
- **Bit timing:** shift SDA in on scl_rise, MSB first. Change i2c_sdat_oe only on scl_fall.
- **States:**
  - **IDLE:** ignore everything but START.
  - **DEV_ADDR:** collect 8 bits.
    - Match ([7:1] == DEVICE_ADDR) → assert oe on the scl_fall after bit 8. Go to ACK_ADDR, then to REG_PTR if R/W = 0, or RD_LOAD if R/W = 1.
    - No match → IDLE; oe stays 0.
  - **ACK_ADDR:** hold oe = 1 until the next scl_fall (end of the 9th clock), then release or start driving data.
  - **REG_PTR:** collect 8 bits. Then ACK, load reg_addr, go to WR_DATA. No reg_wr_en is issued for the pointer byte.
  - **WR_DATA:** collect 8 bits. On the 8th scl_rise pulse reg_wr_en for one cycle with reg_wr_data and the current reg_addr. Then ACK, reg_addr += 1 (8-bit wrap 0xFF → 0x00), loop to WR_DATA.
  - **RD_LOAD (one cycle):** at the ACK-ending scl_fall, latch reg_rd_data into the shift register, pulse reg_rd_en, reg_addr += 1 (wrap).
  - **RD_DATA:** on the same scl_fall and each subsequent scl_fall, drive oe = ~current_bit, MSB first, 8 bits.
  - **RD_ACK:** release oe after bit 8. Sample the master's ACK on scl_rise.
    - ACK (0) → RD_LOAD for the next byte.
    - NACK (1) → wait for STOP/START with oe = 0.
- **Pointer on read:** a read without a preceding pointer write starts at the retained reg_addr.
- **Incomplete bytes:** START or STOP mid-byte aborts the byte; no strobe fires and the partial bits are discarded.
- **Reset:**
  - Reset values: i2c_sdat_oe = 0, reg_addr = 8'h00, reg_wr_en = 0, reg_wr_data = 0, reg_rd_en = 0, busy = 0, state IDLE; filters reset to level 1.
  - Reset mid-transaction releases SDA on the next cycle.
- **Timing and strobes:**
  - Latency from a raw pin edge to the internal edge pulse = 2 + FILTER_LEN clk.
  - i2c_sdat_oe changes ≤ 1 clk after filtered scl_fall.
  - reg_wr_en and reg_rd_en are never asserted in the same cycle, and never for a non-matching address.

Test Plan:
- **Single write:** 400 kHz initiator, clk 50 MHz; START, 0x42, 0x12, 0x80, STOP → ACK on all 3 bytes; one reg_wr_en with reg_addr = 0x12, reg_wr_data = 0x80; reg_addr = 0x13 after.
- **Split read (initiator-style):** START 0x42 0x0A STOP, START 0x43; model returns 0x77 at 0x0A → SDA carries 0111_0111, reg_rd_en once, initiator NACK, STOP → oe = 0, busy = 0, reg_addr = 0x0B.
- **Burst write with wrap:** START 0x42 0xFE, data 0xAA 0xBB 0xCC → writes at 0xFE, 0xFF, 0x00; reg_addr = 0x01.
- **Wrong address:** START 0x60 0x12 0x34 STOP → no ACK (SDA high on all 9th clocks), no strobes, busy = 0.
- **Abort and glitch:** STOP after 4 bits of a data byte → no reg_wr_en. A 2-clk SCL glitch with FILTER_LEN = 4 → no bit is shifted.
- **Reset mid-ACK:** assert rst while oe = 1 → oe = 0 the next cycle, reg_addr = 0x00; the following transaction works normally.
